// File: rtl/decoupler_pkg.sv
// Shared decoupler definitions: output FSM encoding, terminator fill value and
// the pointer/count width helper used by the buffer and the top level.
package decoupler_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_EMPTY = 2'd0;
    localparam state_t ST_LO    = 2'd1;
    localparam state_t ST_HI    = 2'd2;

    // An element made entirely of this bit value marks end-of-stream.
    localparam logic TERM_FILL = 1'b0;

    // Smallest n with 2**n >= value.
    function automatic int unsigned log2_ceil(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/decoupler_if.sv
// Enqueue/dequeue bundle of the decoupler: wide records in, narrow elements out.
// The slave modport is the decoupler side, the master modport is its user.
interface decoupler_if #(
    parameter int unsigned P_WIDTH = 512
);

    logic [2*P_WIDTH-1:0] i_data;
    logic                 i_enq;
    logic                 o_full;
    logic [P_WIDTH-1:0]   o_data;
    logic                 i_deq;
    logic                 o_empty;

    modport master (
        output i_data,
        output i_enq,
        output i_deq,
        input  o_full,
        input  o_data,
        input  o_empty
    );

    modport slave (
        input  i_data,
        input  i_enq,
        input  i_deq,
        output o_full,
        output o_data,
        output o_empty
    );

endinterface

// File: rtl/decoupler_buf.sv
// Circular record buffer feeding the decoupler output stage. Full is registered;
// the head entry and the empty flag are decoded combinationally from state.
module decoupler_buf
    import decoupler_pkg::*;
#(
    parameter  int unsigned WIDTH = 1024,
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned PTR_W = log2_ceil(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enq,
    input  logic [WIDTH-1:0] wdata,
    input  logic             deq,
    output logic [WIDTH-1:0] head_c,
    output logic             full,
    output logic             empty_c
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             push_c, pop_c;
    logic [WIDTH-1:0] mem_q [DEPTH];

    // A push while full is dropped regardless of a same-cycle pop.
    always_comb begin
        push_c   = enq && !full_q;
        pop_c    = deq && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        full_d = (count_d == CNT_W'(DEPTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign head_c  = mem_q[rd_ptr_q];
    assign empty_c = (count_q == '0);
    assign full    = full_q;

endmodule

// File: rtl/decoupler.sv
// Splits buffered {second, first} records into a first-word-fall-through stream of
// P_WIDTH elements. Define DECOUPLER_TERM_COLLAPSE_EN to drop the padding half after a terminator.
module decoupler
    import decoupler_pkg::*;
#(
    parameter int unsigned P_WIDTH = 512,
    parameter int unsigned DEPTH   = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    decoupler_if.slave   bus
);

    localparam int unsigned REC_W = 2 * P_WIDTH;

    state_t             state_q, state_d;
    logic [P_WIDTH-1:0] data_q, data_d;
    logic [P_WIDTH-1:0] hold_q, hold_d;
    logic               empty_q, empty_d;
    logic               refill_c;
    logic               pop_c;
    logic [REC_W-1:0]   head_c;
    logic               buf_empty_c;
    logic               buf_full;

    decoupler_buf #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk     (i_clk),
        .rst     (i_rst),
        .enq     (bus.i_enq),
        .wdata   (bus.i_data),
        .deq     (pop_c),
        .head_c  (head_c),
        .full    (buf_full),
        .empty_c (buf_empty_c)
    );

    // Output stage: present first, then second; refill straight into LO when possible.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        hold_d   = hold_q;
        refill_c = 1'b0;
        pop_c    = 1'b0;

        case (state_q)
            ST_EMPTY: refill_c = 1'b1;
            ST_LO: begin
                if (bus.i_deq) begin
`ifdef DECOUPLER_TERM_COLLAPSE_EN
                    if (data_q == {P_WIDTH{TERM_FILL}}) begin
                        refill_c = 1'b1;
                    end else begin
                        data_d  = hold_q;
                        state_d = ST_HI;
                    end
`else
                    data_d  = hold_q;
                    state_d = ST_HI;
`endif
                end
            end
            ST_HI: begin
                if (bus.i_deq) begin
                    refill_c = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        if (refill_c) begin
            if (!buf_empty_c) begin
                pop_c   = 1'b1;
                data_d  = head_c[P_WIDTH-1:0];
                hold_d  = head_c[REC_W-1:P_WIDTH];
                state_d = ST_LO;
            end else begin
                state_d = ST_EMPTY;
            end
        end

        empty_d = (state_d == ST_EMPTY);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            hold_q  <= '0;
            empty_q <= 1'b1;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            hold_q  <= hold_d;
            empty_q <= empty_d;
        end
    end

    assign bus.o_data  = data_q;
    assign bus.o_empty = empty_q;
    assign bus.o_full  = buf_full;

endmodule

// File: tb/tb_decoupler.sv
// Self-checking bench for decoupler (P_WIDTH=8, DEPTH=4); the expected element
// stream comes from splitting each accepted record by the stream rules.
module tb_decoupler;

    localparam int unsigned PW    = 8;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    decoupler_if #(.P_WIDTH(PW)) bus ();

    decoupler #(
        .P_WIDTH (PW),
        .DEPTH   (DEPTH)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [PW-1:0] exp_q[$];

    // Reference: a record contributes first, then second unless collapsed after a terminator.
    function automatic void model_push(input logic [2*PW-1:0] rec);
        exp_q.push_back(rec[PW-1:0]);
`ifdef DECOUPLER_TERM_COLLAPSE_EN
        if (rec[PW-1:0] != '0) exp_q.push_back(rec[2*PW-1:PW]);
`else
        exp_q.push_back(rec[2*PW-1:PW]);
`endif
    endfunction

    task automatic test_reset();
        bus.i_data = '0;
        bus.i_enq  = 1'b0;
        bus.i_deq  = 1'b0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        checks++;
        if (bus.o_empty !== 1'b1 || bus.o_full !== 1'b0 || bus.o_data !== 8'h00) begin
            errors++;
            $display("FAIL reset: empty=%b full=%b data=%h, want 1 0 00", bus.o_empty, bus.o_full, bus.o_data);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        @(negedge clk);
        bus.i_data = {8'h22, 8'h11};
        bus.i_enq  = 1'b1;
        bus.i_deq  = 1'b1;
        @(negedge clk);
        bus.i_enq = 1'b0;
        checks++;
        if (bus.o_empty !== 1'b1) begin
            errors++;
            $display("FAIL basic_latency: empty=%b after enq edge, want 1", bus.o_empty);
        end
        @(negedge clk);
        checks++;
        if (bus.o_empty !== 1'b0 || bus.o_data !== 8'h11) begin
            errors++;
            $display("FAIL basic_first: empty=%b data=%h, want 0 11", bus.o_empty, bus.o_data);
        end
        @(negedge clk);
        checks++;
        if (bus.o_empty !== 1'b0 || bus.o_data !== 8'h22) begin
            errors++;
            $display("FAIL basic_second: empty=%b data=%h, want 0 22", bus.o_empty, bus.o_data);
        end
        @(negedge clk);
        checks++;
        if (bus.o_empty !== 1'b1) begin
            errors++;
            $display("FAIL basic_drained: empty=%b, want 1", bus.o_empty);
        end
        bus.i_deq = 1'b0;
    endtask

    // One record gets staged, four more fill the buffer, the sixth is dropped.
    task automatic test_full();
        logic [2*PW-1:0] rec;
        exp_q.delete();
        bus.i_deq = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (bus.o_full !== (k == 5)) begin
                errors++;
                $display("FAIL full_flag[%0d]: full=%b, want %b", k, bus.o_full, (k == 5));
            end
            rec = {8'(8'hA1 + 2 * k), 8'(8'hA0 + 2 * k)};
            bus.i_data = rec;
            bus.i_enq  = 1'b1;
            if (k < 5) model_push(rec);
        end
        @(negedge clk);
        bus.i_enq = 1'b0;
        checks++;
        if (bus.o_full !== 1'b1) begin
            errors++;
            $display("FAIL full_hold: full=%b after dropped enq, want 1", bus.o_full);
        end
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (bus.o_empty !== 1'b0 || exp_q.size() == 0) begin
                errors++;
                $display("FAIL full_drain_bubble[%0d]: empty=%b left=%0d", i, bus.o_empty, exp_q.size());
            end else begin
                if (bus.o_data !== exp_q[0]) begin
                    errors++;
                    $display("FAIL full_drain_data[%0d]: got %h, want %h", i, bus.o_data, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
            bus.i_deq = 1'b1;
        end
        @(negedge clk);
        bus.i_deq = 1'b0;
        checks++;
        if (bus.o_empty !== 1'b1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL full_drain_end: empty=%b left=%0d, want 1 0", bus.o_empty, exp_q.size());
        end
    endtask

    task automatic test_term();
        logic [PW-1:0] want [2];
        int n;
        int idx;
        want[0] = 8'h00;
        want[1] = 8'h00;
`ifdef DECOUPLER_TERM_COLLAPSE_EN
        n = 1;
`else
        n = 2;
`endif
        idx = 0;
        @(negedge clk);
        bus.i_data = {8'h00, 8'h00};
        bus.i_enq  = 1'b1;
        bus.i_deq  = 1'b1;
        @(negedge clk);
        bus.i_enq = 1'b0;
        for (int c = 0; c < 20 && idx < n; c++) begin
            @(negedge clk);
            if (!bus.o_empty) begin
                checks++;
                if (bus.o_data !== want[idx]) begin
                    errors++;
                    $display("FAIL term_data[%0d]: got %h, want %h", idx, bus.o_data, want[idx]);
                end
                idx++;
            end
        end
        @(negedge clk);
        checks++;
        if (idx != n || bus.o_empty !== 1'b1) begin
            errors++;
            $display("FAIL term_count: elements=%0d empty=%b, want %0d 1", idx, bus.o_empty, n);
        end
        bus.i_deq = 1'b0;
    endtask

    task automatic test_order();
        logic [PW-1:0] want [4];
        int idx;
        want[0] = 8'h33;
        want[1] = 8'h00;
        want[2] = 8'h44;
        want[3] = 8'h55;
        idx = 0;
        @(negedge clk);
        bus.i_data = {8'h00, 8'h33};
        bus.i_enq  = 1'b1;
        bus.i_deq  = 1'b1;
        @(negedge clk);
        bus.i_data = {8'h55, 8'h44};
        for (int c = 0; c < 20 && idx < 4; c++) begin
            @(negedge clk);
            bus.i_enq = 1'b0;
            if (!bus.o_empty) begin
                checks++;
                if (bus.o_data !== want[idx]) begin
                    errors++;
                    $display("FAIL order_data[%0d]: got %h, want %h", idx, bus.o_data, want[idx]);
                end
                idx++;
            end
        end
        @(negedge clk);
        checks++;
        if (idx != 4 || bus.o_empty !== 1'b1) begin
            errors++;
            $display("FAIL order_count: elements=%0d empty=%b, want 4 1", idx, bus.o_empty);
        end
        bus.i_deq = 1'b0;
    endtask

    // Random enq/deq over 100 incrementing records; held output must not change.
    task automatic test_stall();
        logic [2*PW-1:0] rec;
        logic [PW-1:0]   prev_data;
        logic            prev_hold;
        logic            deq;
        int              sent;
        exp_q.delete();
        sent      = 0;
        prev_hold = 1'b0;
        prev_data = '0;
        for (int c = 0; c < 5000 && (sent < 100 || exp_q.size() != 0); c++) begin
            @(negedge clk);
            if (prev_hold) begin
                checks++;
                if (bus.o_empty !== 1'b0 || bus.o_data !== prev_data) begin
                    errors++;
                    $display("FAIL stall_stable: empty=%b data=%h, want 0 %h", bus.o_empty, bus.o_data, prev_data);
                end
            end
            deq = 1'($urandom_range(0, 1));
            if (deq && !bus.o_empty) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stall_extra: got %h, want nothing", bus.o_data);
                end else begin
                    if (bus.o_data !== exp_q[0]) begin
                        errors++;
                        $display("FAIL stall_data: got %h, want %h", bus.o_data, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
            end
            prev_hold = !bus.o_empty && !deq;
            prev_data = bus.o_data;
            bus.i_deq = deq;
            if (sent < 100 && $urandom_range(0, 1) == 1) begin
                rec = {8'(2 * sent + 2), 8'(2 * sent + 1)};
                bus.i_data = rec;
                bus.i_enq  = 1'b1;
                if (!bus.o_full) begin
                    model_push(rec);
                    sent++;
                end
            end else begin
                bus.i_enq = 1'b0;
            end
        end
        @(negedge clk);
        bus.i_enq = 1'b0;
        bus.i_deq = 1'b0;
        checks++;
        if (sent != 100 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL stall_done: sent=%0d left=%0d, want 100 0", sent, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int idx;
        logic [PW-1:0] want [2];
        @(negedge clk);
        bus.i_deq  = 1'b0;
        bus.i_enq  = 1'b1;
        bus.i_data = {8'h12, 8'h34};
        @(negedge clk);
        bus.i_data = {8'h56, 8'h78};
        @(negedge clk);
        bus.i_data = {8'h9A, 8'hBC};
        @(negedge clk);
        bus.i_enq = 1'b0;
        checks++;
        if (bus.o_empty !== 1'b0 || bus.o_data !== 8'h34) begin
            errors++;
            $display("FAIL mid_lo: empty=%b data=%h, want 0 34", bus.o_empty, bus.o_data);
        end
        bus.i_deq = 1'b1;
        @(negedge clk);
        bus.i_deq = 1'b0;
        checks++;
        if (bus.o_empty !== 1'b0 || bus.o_data !== 8'h12) begin
            errors++;
            $display("FAIL mid_hi: empty=%b data=%h, want 0 12", bus.o_empty, bus.o_data);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.o_empty !== 1'b1 || bus.o_full !== 1'b0 || bus.o_data !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset: empty=%b full=%b data=%h, want 1 0 00", bus.o_empty, bus.o_full, bus.o_data);
        end
        @(negedge clk);
        rst = 1'b0;
        want[0] = 8'h77;
        want[1] = 8'h66;
        idx = 0;
        @(negedge clk);
        bus.i_data = {8'h66, 8'h77};
        bus.i_enq  = 1'b1;
        bus.i_deq  = 1'b1;
        @(negedge clk);
        bus.i_enq = 1'b0;
        for (int c = 0; c < 20 && idx < 2; c++) begin
            @(negedge clk);
            if (!bus.o_empty) begin
                checks++;
                if (bus.o_data !== want[idx]) begin
                    errors++;
                    $display("FAIL mid_after[%0d]: got %h, want %h", idx, bus.o_data, want[idx]);
                end
                idx++;
            end
        end
        @(negedge clk);
        checks++;
        if (idx != 2 || bus.o_empty !== 1'b1) begin
            errors++;
            $display("FAIL mid_after_end: elements=%0d empty=%b, want 2 1", idx, bus.o_empty);
        end
        bus.i_deq = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_term();
        test_order();
        test_stall();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
